// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, well-known register indices,
// and the dump sequencer's state and output-word types.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = $clog2(NREGS);

  localparam logic [ADDR_W-1:0] REG_PU = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] REG_SP = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] REG_PC = ADDR_W'(15);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } dump_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } dump_word_t;

  // Number of registers in the wrapping inclusive range first..last (1..NREGS).
  function automatic logic [ADDR_W:0] range_len(input logic [ADDR_W-1:0] first,
                                                input logic [ADDR_W-1:0] last);
    logic [ADDR_W-1:0] span;
    span = last - first;
    return (ADDR_W+1)'(span) + (ADDR_W+1)'(1);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry head-driven FIFO of dump words; push and pop may coincide even when full.
module skid_fifo2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  dump_word_t push_word,
  input  logic       pop,
  output dump_word_t head,
  output logic [1:0] cnt
);

  dump_word_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt_q;

  // When full, the write slot equals the slot being popped, so a simultaneous
  // push/pop overwrites the departing head and the count stays at 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];
  assign cnt  = cnt_q;

endmodule

// File: rtl/regfile_dump_streamer.sv
// Walks a wrapping range of register-file indices on the read port and streams
// {index, data} words out on a valid/ready master interface.
module regfile_dump_streamer
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic              done_q;

  logic              flush;
  logic              capture;
  logic              pop;
  logic              accept_start;
  logic              final_pop;
  logic [1:0]        fifo_cnt;
  dump_word_t        head;
  dump_word_t        push_word;

  assign m_valid      = (fifo_cnt != 2'd0);
  assign pop          = m_valid & m_ready;
  assign capture      = (state_q == RUN) & ((fifo_cnt < 2'd2) | pop);
  assign accept_start = (state_q == IDLE) & start & ~abort;
  assign final_pop    = (state_q == DRAIN) & ~abort & pop & head.last;

  always_comb begin
    push_word      = '0;
    push_word.addr = rf_addr_q;
    push_word.data = rf_data;
    push_word.last = (remaining_q == (ADDR_W+1)'(1));
  end

  // Abort outranks everything outside IDLE: the FIFO flush also suppresses
  // any push or pop that would otherwise land on the same edge.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_start) state_d = RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (capture && push_word.last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (final_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_addr_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= final_pop;
      if (accept_start) begin
        rf_addr_q   <= first_addr;
        remaining_q <= range_len(first_addr, last_addr);
      end else if (capture && !abort) begin
        rf_addr_q   <= rf_addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - (ADDR_W+1)'(1);
      end
    end
  end

  skid_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (capture),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign rf_en   = (state_q == RUN);
  assign rf_addr = rf_addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_data  = head.data;
  assign m_addr  = head.addr;
  assign m_last  = head.last;

endmodule
